// File: rtl/pwm_deadtime_stage.sv
// PWM output stage: double-buffered duty with valid/ready update, unsigned
// duty/count compare, and a complementary high/low pair with dead time.
module pwm_deadtime_stage #(
    parameter int BIT_WIDTH = 16,
    parameter int DEAD_TIME = 4
) (
    input  logic                 MClk,
    input  logic                 Reset_n,
    input  logic                 Enable,
    input  logic [BIT_WIDTH-1:0] Count,
    input  logic                 Done,
    input  logic [BIT_WIDTH-1:0] Duty,
    input  logic                 DutyValid,
    output logic                 DutyReady,
    output logic                 Update,
    output logic                 PwmHigh,
    output logic                 PwmLow
);

    // Dead counter counts down from DEAD_TIME-1 to 0, giving DEAD_TIME cycles.
    localparam logic [7:0] DeadLoad = (DEAD_TIME == 0) ? 8'd0 : 8'(DEAD_TIME - 1);
    localparam bit         NoDead   = (DEAD_TIME == 0);

    typedef enum logic [1:0] {IDLE, HI, LO, DEAD} state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] active;
    logic [BIT_WIDTH-1:0] shadow;
    logic                 pending;
    logic                 raw_q;
    logic                 target;
    logic [7:0]           dead_cnt;
    logic                 apply;
    logic                 xfer;

    // A pending duty moves over at a period end, or at once while disabled.
    assign apply = pending && (!Enable || Done);
    assign xfer  = DutyValid && DutyReady;

    // Shadow/active duty registers and the update handshake.
    always_ff @(posedge MClk or negedge Reset_n) begin
        if (!Reset_n) begin
            active    <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            DutyReady <= 1'b1;
            Update    <= 1'b0;
        end else begin
            Update <= 1'b0;
            if (apply) begin
                active    <= shadow;
                pending   <= 1'b0;
                DutyReady <= 1'b1;
                Update    <= 1'b1;
            end else if (xfer) begin
                shadow    <= Duty;
                pending   <= 1'b1;
                DutyReady <= 1'b0;
            end
        end
    end

    // Registered raw compare; active = 0 is always low, active > MaxCount always high.
    always_ff @(posedge MClk or negedge Reset_n) begin
        if (!Reset_n) raw_q <= 1'b0;
        else          raw_q <= Enable && (Count < active);
    end

    // Output FSM; outputs are registered alongside the state so they never overlap.
    always_ff @(posedge MClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            target   <= 1'b0;
            dead_cnt <= '0;
            PwmHigh  <= 1'b0;
            PwmLow   <= 1'b0;
        end else if (!Enable) begin
            state   <= IDLE;
            PwmHigh <= 1'b0;
            PwmLow  <= 1'b0;
        end else begin
            case (state)
                DEAD: begin
                    // A raw change during the gap retargets and restarts the gap.
                    if (raw_q != target) begin
                        target   <= raw_q;
                        dead_cnt <= DeadLoad;
                    end else if (dead_cnt == 8'd0) begin
                        state   <= target ? HI : LO;
                        PwmHigh <= target;
                        PwmLow  <= !target;
                    end else begin
                        dead_cnt <= dead_cnt - 8'd1;
                    end
                end
                default: begin
                    // IDLE always leaves; HI/LO leave when raw disagrees with them.
                    // In every case the new target is the current raw level.
                    if (state == IDLE || raw_q != (state == HI)) begin
                        if (NoDead) begin
                            state   <= raw_q ? HI : LO;
                            PwmHigh <= raw_q;
                            PwmLow  <= !raw_q;
                        end else begin
                            state    <= DEAD;
                            target   <= raw_q;
                            dead_cnt <= DeadLoad;
                            PwmHigh  <= 1'b0;
                            PwmLow   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
